// File: rtl/regfile_2w2r_bypass.sv
// ============================================================================
// Module   : regfile_2w2r_bypass
// Brief    : 2-write / 2-read register file with write-first bypass,
//            optional hard-wired zero entry and a sequenced clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_2w2r_bypass #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_req,
   output logic              ready,
   input  logic              we0,
   input  logic [ADDR_W-1:0] waddr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] waddr1,
   input  logic [DATA_W-1:0] wdata1,
   input  logic [ADDR_W-1:0] raddr0,
   output logic [DATA_W-1:0] rdata0,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1
);

   localparam int                DEPTH    = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
   localparam logic              HAS_ZERO = (ZERO_REG != 0);
   localparam logic              HAS_BYP  = (BYPASS != 0);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              wr0_ok, wr1_ok;

   // A write is effective only if enabled and not aimed at the hard-wired zero entry.
   assign wr0_ok = we0 && !(HAS_ZERO && (waddr0 == '0));
   assign wr1_ok = we1 && !(HAS_ZERO && (waddr1 == '0));
   assign ready  = (state == ST_READY);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_CLEAR;
         clr_cnt <= '0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      case (state)
         ST_CLEAR: begin
            clr_cnt_nxt = clr_cnt + 1'b1;
            if (clr_cnt == LAST_IDX) begin
               state_nxt = ST_READY;
            end
         end
         ST_READY: begin
            if (clear_req) begin
               state_nxt   = ST_CLEAR;
               clr_cnt_nxt = '0;
            end
         end
         default: begin
            state_nxt   = ST_CLEAR;
            clr_cnt_nxt = '0;
         end
      endcase
   end

   // Port 1 is assigned last so it wins a same-address collision.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
         end else begin
            if (wr0_ok) begin
               mem[waddr0] <= wdata0;
            end
            if (wr1_ok) begin
               mem[waddr1] <= wdata1;
            end
         end
      end
   end

   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
      logic [DATA_W-1:0] val;
      val = mem[addr];
      if (HAS_BYP) begin
         if (wr1_ok && (waddr1 == addr)) begin
            val = wdata1;
         end else if (wr0_ok && (waddr0 == addr)) begin
            val = wdata0;
         end
      end
      if ((state != ST_READY) || (HAS_ZERO && (addr == '0))) begin
         val = '0;
      end
      return val;
   endfunction

   assign rdata0 = read_port(raddr0);
   assign rdata1 = read_port(raddr1);

endmodule

`default_nettype wire

// File: tb/tb_regfile_2w2r_bypass.sv
// ============================================================================
// Module   : tb_regfile_2w2r_bypass
// Brief    : Scoreboard bench for regfile_2w2r_bypass across four builds.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_2w2r_bypass;

   localparam int U_A_RD0 = 0, U_A_RD1 = 1, U_A_RDY = 2;
   localparam int U_B_RD0 = 3, U_B_RD1 = 4, U_B_RDY = 5;
   localparam int U_C_RD0 = 6, U_C_RD1 = 7, U_C_RDY = 8;
   localparam int U_D_RD0 = 9, U_D_RD1 = 10, U_D_RDY = 11;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 32-bit / 32-entry group: a = zero reg + bypass, b = no zero reg, no bypass
   logic        rst_b, clr_b, we0_b, we1_b;
   logic [4:0]  waddr0_b, waddr1_b, raddr0_b, raddr1_b;
   logic [31:0] wdata0_b, wdata1_b;
   logic        a_ready, b_ready;
   logic [31:0] a_rdata0, a_rdata1, b_rdata0, b_rdata1;

   // 16-bit / 8-entry group: c = bypass, d = no bypass
   logic        rst_s, clr_s, we0_s, we1_s;
   logic [2:0]  waddr0_s, waddr1_s, raddr0_s, raddr1_s;
   logic [15:0] wdata0_s, wdata1_s;
   logic        c_ready, d_ready;
   logic [15:0] c_rdata0, c_rdata1, d_rdata0, d_rdata1;

   regfile_2w2r_bypass #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
      .clk(clk), .rst(rst_b), .clear_req(clr_b), .ready(a_ready),
      .we0(we0_b), .waddr0(waddr0_b), .wdata0(wdata0_b),
      .we1(we1_b), .waddr1(waddr1_b), .wdata1(wdata1_b),
      .raddr0(raddr0_b), .rdata0(a_rdata0), .raddr1(raddr1_b), .rdata1(a_rdata1));

   regfile_2w2r_bypass #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut_b (
      .clk(clk), .rst(rst_b), .clear_req(clr_b), .ready(b_ready),
      .we0(we0_b), .waddr0(waddr0_b), .wdata0(wdata0_b),
      .we1(we1_b), .waddr1(waddr1_b), .wdata1(wdata1_b),
      .raddr0(raddr0_b), .rdata0(b_rdata0), .raddr1(raddr1_b), .rdata1(b_rdata1));

   regfile_2w2r_bypass #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut_c (
      .clk(clk), .rst(rst_s), .clear_req(clr_s), .ready(c_ready),
      .we0(we0_s), .waddr0(waddr0_s), .wdata0(wdata0_s),
      .we1(we1_s), .waddr1(waddr1_s), .wdata1(wdata1_s),
      .raddr0(raddr0_s), .rdata0(c_rdata0), .raddr1(raddr1_s), .rdata1(c_rdata1));

   regfile_2w2r_bypass #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) dut_d (
      .clk(clk), .rst(rst_s), .clear_req(clr_s), .ready(d_ready),
      .we0(we0_s), .waddr0(waddr0_s), .wdata0(wdata0_s),
      .we1(we1_s), .waddr1(waddr1_s), .wdata1(wdata1_s),
      .raddr0(raddr0_s), .rdata0(d_rdata0), .raddr1(raddr1_s), .rdata1(d_rdata1));

   typedef struct {
      string       tag;
      int          unit;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] observe(input int unit);
      case (unit)
         U_A_RD0: return a_rdata0;
         U_A_RD1: return a_rdata1;
         U_A_RDY: return {31'd0, a_ready};
         U_B_RD0: return b_rdata0;
         U_B_RD1: return b_rdata1;
         U_B_RDY: return {31'd0, b_ready};
         U_C_RD0: return {16'd0, c_rdata0};
         U_C_RD1: return {16'd0, c_rdata1};
         U_C_RDY: return {31'd0, c_ready};
         U_D_RD0: return {16'd0, d_rdata0};
         U_D_RD1: return {16'd0, d_rdata1};
         U_D_RDY: return {31'd0, d_ready};
         default: return 32'hxxxx_xxxx;
      endcase
   endfunction

   task automatic push(input string tag, input int unit, input logic [31:0] exp);
      exp_t e;
      e.tag  = tag;
      e.unit = unit;
      e.exp  = exp;
      sb.push_back(e);
   endtask

   // Lets combinational outputs settle, then retires every pending expectation.
   task automatic drain();
      exp_t e;
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check_value(e.tag, observe(e.unit), e.exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic count_to_ready(input int unit, input string tag, input int exp_cycles);
      int n;
      n = 0;
      while (observe(unit) == 32'd0 && n < 200) begin
         tick();
         n++;
      end
      check_value(tag, 32'(n), 32'(exp_cycles));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, ra, rc;
      rst_b = 1'b1; clr_b = 1'b0; we0_b = 1'b0; we1_b = 1'b0;
      waddr0_b = '0; waddr1_b = '0; wdata0_b = '0; wdata1_b = '0;
      raddr0_b = '0; raddr1_b = '0;
      rst_s = 1'b1; clr_s = 1'b0; we0_s = 1'b0; we1_s = 1'b0;
      waddr0_s = '0; waddr1_s = '0; wdata0_s = '0; wdata1_s = '0;
      raddr0_s = '0; raddr1_s = '0;
      tick();
      tick();
      rst_b = 1'b0;
      rst_s = 1'b0;
      push("rst_ready_a", U_A_RDY, 0);
      push("rst_ready_b", U_B_RDY, 0);
      push("rst_ready_c", U_C_RDY, 0);
      push("rst_ready_d", U_D_RDY, 0);
      drain();

      // Sweep after reset; writes to addr 5 mid-sweep must be ignored.
      cyc = 0; ra = -1; rc = -1;
      while ((ra < 0 || rc < 0) && cyc < 200) begin
         if (cyc >= 8 && cyc < 20) begin
            we0_b = 1'b1; waddr0_b = 5'd5; wdata0_b = 32'h0000_DEAD; raddr0_b = 5'd5;
            push("sweep_rd_a", U_A_RD0, 0);
            push("sweep_rd_b", U_B_RD0, 0);
            drain();
         end else begin
            we0_b = 1'b0;
         end
         tick();
         cyc++;
         if (a_ready && ra < 0) ra = cyc;
         if (c_ready && rc < 0) rc = cyc;
      end
      we0_b = 1'b0;
      check_value("clear_len_a", 32'(ra), 32'd32);
      check_value("clear_len_c", 32'(rc), 32'd8);
      push("ready_b", U_B_RDY, 1);
      push("ready_d", U_D_RDY, 1);
      drain();

      for (int i = 0; i < 32; i++) begin
         raddr0_b = 5'(i);
         raddr1_b = 5'(31 - i);
         push($sformatf("zero_a_rd0_%0d", i), U_A_RD0, 0);
         push($sformatf("zero_a_rd1_%0d", i), U_A_RD1, 0);
         push($sformatf("zero_b_rd0_%0d", i), U_B_RD0, 0);
         push($sformatf("zero_b_rd1_%0d", i), U_B_RD1, 0);
         drain();
      end
      tick();

      // Same-address collision: port 1 wins, bypass shows it in the write cycle.
      we0_b = 1'b1; waddr0_b = 5'd3; wdata0_b = 32'h1111_1111;
      we1_b = 1'b1; waddr1_b = 5'd3; wdata1_b = 32'h2222_2222;
      raddr0_b = 5'd3;
      push("coll_byp_a", U_A_RD0, 32'h2222_2222);
      push("coll_old_b", U_B_RD0, 32'h0);
      drain();
      tick();
      we0_b = 1'b0; we1_b = 1'b0;
      push("coll_stored_a", U_A_RD0, 32'h2222_2222);
      push("coll_stored_b", U_B_RD0, 32'h2222_2222);
      drain();

      // Write to entry 0: dropped when hard-wired, stored otherwise.
      we1_b = 1'b1; waddr1_b = 5'd0; wdata1_b = 32'hFFFF_FFFF; raddr1_b = 5'd0;
      push("zreg_wcyc_a", U_A_RD1, 32'h0);
      push("zreg_wcyc_b", U_B_RD1, 32'h0);
      drain();
      tick();
      we1_b = 1'b0;
      push("zreg_after_a", U_A_RD1, 32'h0);
      push("zreg_after_b", U_B_RD1, 32'hFFFF_FFFF);
      drain();

      // No-bypass build shows the old value during the write cycle.
      we0_b = 1'b1; waddr0_b = 5'd7; wdata0_b = 32'hA5A5_A5A5; raddr0_b = 5'd7;
      push("nobyp_wcyc_a", U_A_RD0, 32'hA5A5_A5A5);
      push("nobyp_wcyc_b", U_B_RD0, 32'h0);
      drain();
      tick();
      we0_b = 1'b0;
      push("nobyp_next_a", U_A_RD0, 32'hA5A5_A5A5);
      push("nobyp_next_b", U_B_RD0, 32'hA5A5_A5A5);
      drain();

      // Concurrent writes to different addresses.
      we0_b = 1'b1; waddr0_b = 5'd1; wdata0_b = 32'h1;
      we1_b = 1'b1; waddr1_b = 5'd2; wdata1_b = 32'h2;
      raddr0_b = 5'd1; raddr1_b = 5'd2;
      push("dual_byp0_a", U_A_RD0, 32'h1);
      push("dual_byp1_a", U_A_RD1, 32'h2);
      push("dual_old0_b", U_B_RD0, 32'h0);
      push("dual_old1_b", U_B_RD1, 32'h0);
      drain();
      tick();
      we0_b = 1'b0; we1_b = 1'b0;
      push("dual_st0_a", U_A_RD0, 32'h1);
      push("dual_st1_a", U_A_RD1, 32'h2);
      push("dual_st0_b", U_B_RD0, 32'h1);
      push("dual_st1_b", U_B_RD1, 32'h2);
      drain();

      // Requested clear.
      clr_b = 1'b1;
      tick();
      clr_b = 1'b0;
      push("clrreq_rdy_a", U_A_RDY, 0);
      push("clrreq_rdy_b", U_B_RDY, 0);
      push("clrreq_forced_a", U_A_RD0, 0);
      drain();
      count_to_ready(U_A_RDY, "clrreq_len_a", 32);
      push("clrreq_done_b", U_B_RDY, 1);
      push("clrreq_rd0_a", U_A_RD0, 0);
      push("clrreq_rd1_a", U_A_RD1, 0);
      push("clrreq_rd0_b", U_B_RD0, 0);
      push("clrreq_rd1_b", U_B_RD1, 0);
      drain();
      raddr0_b = 5'd0;
      push("clrreq_e0_b", U_B_RD0, 0);
      drain();

      // Reset in the middle of a clear restarts the sweep.
      clr_b = 1'b1;
      tick();
      clr_b = 1'b0;
      repeat (10) tick();
      push("midclr_busy_a", U_A_RDY, 0);
      drain();
      rst_b = 1'b1;
      tick();
      rst_b = 1'b0;
      count_to_ready(U_A_RDY, "midclr_len_a", 32);
      push("midclr_done_b", U_B_RDY, 1);
      drain();

      // 16-bit / 8-entry builds.
      we0_s = 1'b1; waddr0_s = 3'd3; wdata0_s = 16'h1111;
      we1_s = 1'b1; waddr1_s = 3'd3; wdata1_s = 16'h2222;
      raddr0_s = 3'd3;
      push("s_coll_byp_c", U_C_RD0, 32'h2222);
      push("s_coll_old_d", U_D_RD0, 32'h0);
      drain();
      tick();
      we0_s = 1'b0; we1_s = 1'b0;
      push("s_coll_st_c", U_C_RD0, 32'h2222);
      push("s_coll_st_d", U_D_RD0, 32'h2222);
      drain();

      we0_s = 1'b1; waddr0_s = 3'd7; wdata0_s = 16'hA5A5; raddr0_s = 3'd7;
      push("s_nobyp_wcyc_c", U_C_RD0, 32'hA5A5);
      push("s_nobyp_wcyc_d", U_D_RD0, 32'h0);
      drain();
      tick();
      we0_s = 1'b0;
      push("s_nobyp_next_c", U_C_RD0, 32'hA5A5);
      push("s_nobyp_next_d", U_D_RD0, 32'hA5A5);
      drain();

      clr_s = 1'b1;
      tick();
      clr_s = 1'b0;
      count_to_ready(U_C_RDY, "s_clrreq_len_c", 8);
      push("s_clrreq_rd_c", U_C_RD0, 0);
      push("s_clrreq_rd_d", U_D_RD0, 0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/regfile_2w2r_bypass.md
Name: regfile_2w2r_bypass

Overview:
Parametrised successor to the core's single-write register file. Provides 2 write ports, 2 read ports, same-cycle write-to-read bypass, an optional hard-wired zero register, and a sequenced clear (one entry per cycle) after reset or on request. It sits in the decode/writeback stage of the dual-issue pipeline and is the single source of architectural register state.

Parameters:
DATA_W, 32, width of each register in bits
ADDR_W, 5, register address width; DEPTH = 2**ADDR_W entries
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is a normal register
BYPASS, 1, 1 = reads return same-cycle write data (write-first); 0 = reads return stored value only

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
clear_req  in  1  pulse: restart the clear sequence while READY
ready  out  1  1 = file usable; 0 = clear sequence in progress
we0  in  1  write enable, port 0
waddr0  in  ADDR_W  write address, port 0
wdata0  in  DATA_W  write data, port 0
we1  in  1  write enable, port 1 (priority port)
waddr1  in  ADDR_W  write address, port 1
wdata1  in  DATA_W  write data, port 1
raddr0  in  ADDR_W  read address, port 0
rdata0  out  DATA_W  read data, port 0 (combinational)
raddr1  in  ADDR_W  read address, port 1
rdata1  out  DATA_W  read data, port 1 (combinational)

Behaviour:
- State machine with states CLEAR and READY, plus clear counter clr_cnt [ADDR_W-1:0].
- rst=1 at an edge: state<=CLEAR, clr_cnt<=0, ready=0 in the following cycle. Takes precedence over everything, including mid-clear (the counter restarts at 0).
- CLEAR: each edge writes 0 to entry clr_cnt and increments clr_cnt. When clr_cnt==DEPTH-1, that entry is written and state<=READY. ready rises exactly DEPTH cycles after the first non-reset edge.
- In CLEAR, we0/we1 are ignored and rdata0/rdata1 are forced to 0. clear_req is ignored.
- READY + clear_req=1: state<=CLEAR, clr_cnt<=0. Writes presented in that same cycle are still committed, but are then overwritten by the sweep.
- Writes (READY only): commit at the rising edge when weN=1.
  - If ZERO_REG=1, writes to address 0 are dropped.
  - If we0 and we1 target the same address, port 1's data is stored.
  - Different addresses: both are stored.
- Reads are asynchronous: rdataN = entry[raddrN], subject to the following overrides:
  - ZERO_REG=1 and raddrN==0 -> rdataN=0, regardless of writes.
  - BYPASS=1: if we1 && waddr1==raddrN (and the address is not a dropped zero-register write) -> rdataN=wdata1; else if the same holds for port 0 -> rdataN=wdata0; else the stored value.
  - BYPASS=0: stored value only; a new write is visible the cycle after the edge.
- Storage is not otherwise reset; contents are defined only after the first completed clear.
- No width conversion: data is passed through unmodified at DATA_W bits.

Test Plan:
1. Assert rst for 1 cycle, then deassert -> ready=0 for exactly 32 cycles, then 1. Reading all 32 addresses returns 0x00000000. During the sweep, a write we0=1 to addr 5 with 0xDEAD is ignored, and addr 5 reads 0 afterwards.
2. READY: we0 addr 3 = 0x11111111 and we1 addr 3 = 0x22222222 in the same cycle -> next cycle raddr0=3 returns 0x22222222. With BYPASS=1, rdata0 shows 0x22222222 combinationally in the write cycle itself.
3. ZERO_REG=1: we1 to addr 0 with 0xFFFFFFFF and raddr1=0 in the same cycle -> rdata1=0 in that cycle and afterwards. Rebuild with ZERO_REG=0 -> next cycle returns 0xFFFFFFFF.
4. BYPASS=0: we0 addr 7 = 0xA5A5A5A5 with raddr0=7 -> rdata0 shows the old value (0) in the write cycle and 0xA5A5A5A5 the next cycle.
5. Concurrent writes: we0 addr 1 = 0x1, we1 addr 2 = 0x2 -> both stored. Then pulse clear_req -> ready drops the next cycle, and both read 0 after 32 cycles.
6. Reset mid-clear: assert rst at clear cycle 10 -> the counter restarts, and ready rises exactly 32 cycles after rst deasserts. Also run with ADDR_W=3, DATA_W=16 -> 8-cycle clear, with checks 2 and 4 repeated at 16-bit width.
